alu_op_ctrl: RTL and testbench
==============================

ALU_OP_CTRL -- requirements
Module: alu_op_ctrl

Interface
REQ-001 Parameter K, default 7: operand/result width in bits.
REQ-002 Parameter MUL_CYC, default 3: cycles the mult unit needs before its output is valid; legal range 1..15.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_op  input  3  0=and, 1=or, 2=xor, 3=not, 4=add/sub, 5=mult, 6..7 illegal.
REQ-008 req_sub  input  1  for op 4: 1=subtract, 0=add.
REQ-009 req_a, req_b  input  K each  operands.
REQ-010 opa, opb  output  K each  registered operands driven to the ALU units.
REQ-011 sub_en  output  1  registered add/sub mode to the add/sub unit.
REQ-012 sel  output  6  registered one-hot select to the output mux, bit order and, or, xor, not, addSub, mult.
REQ-013 mux_out  input  K  output of the select mux.
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  consumer accepts result.
REQ-016 rsp_data  output  K  captured result.
REQ-017 rsp_err  output  1  result belongs to an illegal opcode.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, MULW, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid and req_ready both 1.
REQ-020 On accept, opa/opb/sub_en SHALL load req_a/req_b/req_sub and sel SHALL load the one-hot for req_op.
REQ-021 Legal non-mult op: IDLE->EXEC; in EXEC rsp_data SHALL capture mux_out and the FSM SHALL go to RESP (rsp_valid 2 cycles after accept edge... i.e. asserted on the second rising edge after accept).
REQ-022 Mult op: IDLE->MULW with down-counter loaded to MUL_CYC-1; in MULW counter decrements each cycle; when counter is 0, rsp_data SHALL capture mux_out and FSM SHALL go to RESP (rsp_valid after MUL_CYC+1 edges).
REQ-023 Illegal op (6,7): IDLE->RESP directly, sel SHALL be 6'b0, rsp_data SHALL be 0, rsp_err SHALL be 1.
REQ-024 rsp_err SHALL be 0 for every legal op.
REQ-025 rsp_valid SHALL be 1 exactly in RESP; rsp_data/rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-026 RESP with rsp_ready=1: FSM SHALL return to IDLE, sel SHALL clear to 0; a new request can be accepted the following cycle (no same-cycle accept).
REQ-027 sel SHALL be one-hot or all-zero in every cycle; it SHALL hold its value from accept until RESP exit.
REQ-028 opa/opb/sub_en SHALL hold from accept until the next accept.
REQ-029 Requests presented outside IDLE SHALL be ignored (not lost by the controller: requester holds them per handshake).
REQ-030 No arithmetic in this block beyond the 4-bit mult counter; result width equals K, no truncation or extension.

Reset
REQ-031 On rst_n low, immediately: state=IDLE, sel=0, opa=opb=0, sub_en=0, rsp_data=0, rsp_err=0, rsp_valid=0, counter=0; req_ready=1 after reset releases.
REQ-032 Reset asserted mid-operation (EXEC, MULW or RESP) SHALL abort it with no response emitted.

Structure
REQ-033 Opcode encodings, one-hot select constants and FSM state encoding SHALL live in a shared package alu_pkg.
REQ-034 Opcode-to-one-hot decode SHALL be a combinational sub-module alu_op_decode (op in, sel and illegal flag out); everything else flat.

Verification
REQ-035 K=7, op=0, a=7'h55, b=7'h0F, mux model returns a&b -> sel=6'b000001, rsp_valid after 2 edges, rsp_data=7'h05, rsp_err=0.
REQ-036 op=5, MUL_CYC=3, a=3, b=5 -> sel=6'b100000 held 4 cycles, rsp_valid after 4 edges, rsp_data=7'd15.
REQ-037 op=4, sub=1, a=10, b=3 -> sub_en=1, rsp_data=7; then rsp_ready=0 for 5 cycles -> rsp_data stays 7, req_ready stays 0.
REQ-038 op=6 -> next edge rsp_valid=1, rsp_err=1, rsp_data=0, sel=0.
REQ-039 rst_n pulsed low during MULW -> all outputs zero immediately, req_ready=1 after release, no rsp_valid.
REQ-040 Back-to-back requests with rsp_ready tied 1 -> one accept per op, sel always one-hot or zero, second accept exactly one cycle after first RESP.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation controller: opcodes, one-hot mux
// selects and FSM state encoding.
package alu_pkg;

  localparam int OP_W  = 3;
  localparam int SEL_W = 6;
  localparam int CNT_W = 4;

  localparam logic [OP_W-1:0] OP_AND    = 3'd0;
  localparam logic [OP_W-1:0] OP_OR     = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT    = 3'd3;
  localparam logic [OP_W-1:0] OP_ADDSUB = 3'd4;
  localparam logic [OP_W-1:0] OP_MUL    = 3'd5;

  // Bit order matches the output mux inputs: and, or, xor, not, addSub, mult.
  localparam logic [SEL_W-1:0] SEL_NONE   = 6'b000000;
  localparam logic [SEL_W-1:0] SEL_AND    = 6'b000001;
  localparam logic [SEL_W-1:0] SEL_OR     = 6'b000010;
  localparam logic [SEL_W-1:0] SEL_XOR    = 6'b000100;
  localparam logic [SEL_W-1:0] SEL_NOT    = 6'b001000;
  localparam logic [SEL_W-1:0] SEL_ADDSUB = 6'b010000;
  localparam logic [SEL_W-1:0] SEL_MUL    = 6'b100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULW = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode: one-hot mux select plus illegal-opcode flag.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  output logic [SEL_W-1:0] sel,
  output logic             illegal
);

  // Map each legal opcode to its select line; 6/7 give no select and flag illegal.
  always_comb begin
    sel     = SEL_NONE;
    illegal = 1'b0;
    case (op)
      OP_AND:    sel = SEL_AND;
      OP_OR:     sel = SEL_OR;
      OP_XOR:    sel = SEL_XOR;
      OP_NOT:    sel = SEL_NOT;
      OP_ADDSUB: sel = SEL_ADDSUB;
      OP_MUL:    sel = SEL_MUL;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_ctrl.sv
// ALU operation controller: accepts one request at a time, drives registered
// operands/select to the ALU units, waits for the selected unit, captures the
// mux output and holds it until the consumer takes it.
module alu_op_ctrl
  import alu_pkg::*;
#(
  parameter int K       = 7,
  parameter int MUL_CYC = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic            req_sub,
  input  logic [K-1:0]    req_a,
  input  logic [K-1:0]    req_b,
  output logic [K-1:0]    opa,
  output logic [K-1:0]    opb,
  output logic            sub_en,
  output logic [SEL_W-1:0] sel,
  input  logic [K-1:0]    mux_out,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [K-1:0]    rsp_data,
  output logic            rsp_err
);

  // Mult wait counter starts at MUL_CYC-1 so the capture lands MUL_CYC edges after accept.
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [K-1:0]     opa_q, opa_d, opb_q, opb_d, data_q, data_d;
  logic             sub_q, sub_d, err_q, err_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             rsp_valid_q, rsp_valid_d, req_ready_q, req_ready_d;

  logic [SEL_W-1:0] dec_sel;
  logic             dec_illegal;

  alu_op_decode u_dec (
    .op      (req_op),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  // Next-state and datapath load decisions for the controller FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sub_d   = sub_q;
    sel_d   = sel_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          opa_d = req_a;
          opb_d = req_b;
          sub_d = req_sub;
          sel_d = dec_sel;
          err_d = dec_illegal;
          if (dec_illegal) begin
            data_d  = '0;
            state_d = ST_RESP;
          end else if (req_op == OP_MUL) begin
            cnt_d   = MUL_LD;
            state_d = ST_MULW;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        data_d  = mux_out;
        state_d = ST_RESP;
      end
      ST_MULW: begin
        if (cnt_q == '0) begin
          data_d  = mux_out;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          sel_d   = SEL_NONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rsp_valid_d = (state_d == ST_RESP);
    req_ready_d = (state_d == ST_IDLE);
  end

  // Register FSM state, datapath holding registers and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      sub_q       <= 1'b0;
      sel_q       <= SEL_NONE;
      data_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sub_q       <= sub_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  assign opa       = opa_q;
  assign opb       = opb_q;
  assign sub_en    = sub_q;
  assign sel       = sel_q;
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign rsp_valid = rsp_valid_q;
  assign req_ready = req_ready_q;

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Bench for alu_op_ctrl: transaction-level latency model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_op_ctrl;
  localparam int K       = 7;
  localparam int MUL_CYC = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = '0;
  logic         req_sub = 1'b0;
  logic [K-1:0] req_a = '0, req_b = '0;
  logic [K-1:0] opa, opb, mux_out, rsp_data;
  logic         sub_en, rsp_valid, rsp_err;
  logic         rsp_ready = 1'b0;
  logic [5:0]   sel;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  alu_op_ctrl #(.K(K), .MUL_CYC(MUL_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .opa(opa), .opb(opb), .sub_en(sub_en), .sel(sel), .mux_out(mux_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  // Stand-in for the ALU units and output mux.
  always_comb begin
    mux_out = '0;
    case (sel)
      6'b000001: mux_out = opa & opb;
      6'b000010: mux_out = opa | opb;
      6'b000100: mux_out = opa ^ opb;
      6'b001000: mux_out = ~opa;
      6'b010000: mux_out = sub_en ? opa - opb : opa + opb;
      6'b100000: mux_out = opa * opb;
      default:   mux_out = '0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [K-1:0] ref_alu(input int op, input logic s, input logic [K-1:0] a, input logic [K-1:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~a;
      4: return s ? K'(int'(a) - int'(b)) : K'(int'(a) + int'(b));
      5: return K'(int'(a) * int'(b));
      default: return '0;
    endcase
  endfunction

  function automatic logic [5:0] ref_sel(input int op);
    return (op < 6) ? 6'(1 << op) : 6'd0;
  endfunction

  // Model: busy for a fixed number of edges per op, then a response held until taken.
  logic         m_resp = 1'b0;
  int           m_wait = 0;
  logic [5:0]   m_sel = '0;
  logic [K-1:0] m_opa = '0, m_opb = '0, m_res = '0, m_data = '0;
  logic         m_sub = 1'b0, m_err = 1'b0;
  int           m_acc = 0;
  logic         m_idle;
  assign m_idle = !m_resp && (m_wait == 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_resp <= 1'b0; m_wait <= 0; m_sel <= '0; m_opa <= '0; m_opb <= '0;
      m_sub <= 1'b0; m_data <= '0; m_err <= 1'b0;
    end else if (m_resp) begin
      if (rsp_ready) begin
        m_resp <= 1'b0;
        m_sel  <= '0;
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_resp <= 1'b1;
        m_data <= m_res;
      end
    end else if (req_valid) begin
      m_acc <= m_acc + 1;
      m_opa <= req_a;
      m_opb <= req_b;
      m_sub <= req_sub;
      m_sel <= ref_sel(int'(req_op));
      m_err <= (req_op > 3'd5);
      m_res <= ref_alu(int'(req_op), req_sub, req_a, req_b);
      if (req_op > 3'd5) begin
        m_data <= '0;
        m_resp <= 1'b1;
      end else begin
        m_wait <= (req_op == 3'd5) ? MUL_CYC : 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(m_idle));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("sel_onehot0", 32'($onehot0(sel)), 32'd1);
    chk("opa", 32'(opa), 32'(m_opa));
    chk("opb", 32'(opb), 32'(m_opb));
    chk("sub_en", 32'(sub_en), 32'(m_sub));
    if (m_resp) begin
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
  end

  // Accept counting and back-to-back gap measurement.
  int   d_acc = 0, cyc = 0, last_exit = -1;
  logic b2b = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && req_valid && req_ready) begin
      d_acc <= d_acc + 1;
      if (b2b && last_exit >= 0) chk("b2b_gap", 32'(cyc), 32'(last_exit + 1));
    end
    if (!b2b) last_exit <= -1;
    else if (rst_n && rsp_valid && rsp_ready) last_exit <= cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [2:0] op, input logic s, input logic [K-1:0] a, input logic [K-1:0] b);
    req_op = op; req_sub = s; req_a = a; req_b = b; req_valid = 1'b1;
  endtask

  initial begin
    // Reset state
    step(); step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_opa", 32'(opa), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // AND: 0x55 & 0x0F
    rsp_ready = 1'b1;
    put(3'd0, 1'b0, 7'h55, 7'h0F);
    step(); req_valid = 1'b0;
    chk("and_sel", 32'(sel), 32'b000001);
    chk("and_early_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("and_valid", 32'(rsp_valid), 32'd1);
    chk("and_data", 32'(rsp_data), 32'h05);
    chk("and_err", 32'(rsp_err), 32'd0);
    step();
    chk("and_idle", 32'(req_ready), 32'd1);
    chk("and_sel_clr", 32'(sel), 32'd0);

    // MULT: 3*5 with MUL_CYC=3
    rsp_ready = 1'b0;
    put(3'd5, 1'b0, 7'd3, 7'd5);
    step(); req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("mul_sel_hold", 32'(sel), 32'b100000);
      chk("mul_early_valid", 32'(rsp_valid), 32'd0);
      step();
    end
    chk("mul_valid", 32'(rsp_valid), 32'd1);
    chk("mul_data", 32'(rsp_data), 32'd15);
    chk("mul_sel_resp", 32'(sel), 32'b100000);
    rsp_ready = 1'b1;
    step();

    // SUB: 10-3 then stall; a conflicting request is ignored meanwhile
    rsp_ready = 1'b0;
    put(3'd4, 1'b1, 7'd10, 7'd3);
    step(); req_valid = 1'b0;
    chk("sub_en", 32'(sub_en), 32'd1);
    step();
    chk("sub_valid", 32'(rsp_valid), 32'd1);
    chk("sub_data", 32'(rsp_data), 32'd7);
    put(3'd0, 1'b0, 7'd1, 7'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_data", 32'(rsp_data), 32'd7);
      chk("stall_ready", 32'(req_ready), 32'd0);
      chk("stall_opa", 32'(opa), 32'd10);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    chk("stall_exit_ready", 32'(req_ready), 32'd1);

    // Illegal opcode 6
    rsp_ready = 1'b0;
    put(3'd6, 1'b0, 7'h7F, 7'h7F);
    step(); req_valid = 1'b0;
    chk("ill_valid", 32'(rsp_valid), 32'd1);
    chk("ill_err", 32'(rsp_err), 32'd1);
    chk("ill_data", 32'(rsp_data), 32'd0);
    chk("ill_sel", 32'(sel), 32'd0);
    rsp_ready = 1'b1;
    step();

    // Reset pulsed mid-MULW
    rsp_ready = 1'b0;
    put(3'd5, 1'b1, 7'd9, 7'd9);
    step(); req_valid = 1'b0;
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_opa", 32'(opa), 32'd0);
    chk("abort_opb", 32'(opb), 32'd0);
    chk("abort_sub", 32'(sub_en), 32'd0);
    chk("abort_data", 32'(rsp_data), 32'd0);
    chk("abort_err", 32'(rsp_err), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd1);
    end

    // Back-to-back with rsp_ready tied high
    rsp_ready = 1'b1; b2b = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 80; i++) begin
      req_op = 3'($urandom_range(0, 7)); req_sub = 1'($urandom_range(0, 1));
      req_a = K'($urandom); req_b = K'($urandom);
      step();
    end
    req_valid = 1'b0; b2b = 1'b0;
    repeat (6) step();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_op = 3'($urandom_range(0, 7)); req_sub = 1'($urandom_range(0, 1));
      req_a = K'($urandom); req_b = K'($urandom);
      step();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (8) step();
    chk("accept_count", 32'(d_acc), 32'(m_acc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
